// File: rtl/reset_sequencer.sv
// Multi-channel reset generator: minimum hold, staged in-order release, global and per-channel assert.
// Optional RESET_SEQUENCER_CASCADE_EN: a channel assert also asserts all higher channels; RUN release is ordered.
module reset_sequencer #(
  parameter int NCH         = 4,
  parameter int HOLD        = 8,
  parameter int GAP         = 2,
  parameter int INIT_ASSERT = 1
) (
  input  logic           CLK,
  input  logic           RST_N,
  input  logic           ASSERT_ALL,
  input  logic [NCH-1:0] ASSERT_IN,
  output logic [NCH-1:0] OUT_RST_N,
  output logic [NCH-1:0] ASSERT_OUT,
  output logic           BUSY
);

  localparam int CW = $clog2(HOLD + 1);
  localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;
  localparam int IW = (NCH > 1) ? $clog2(NCH) : 1;

  localparam logic [CW-1:0] CNT_HOLD = CW'(HOLD);
  localparam logic [CW-1:0] CNT_INIT = CW'(HOLD - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP);
  localparam logic [GW-1:0] GAP_ONE  = GW'(1);
  localparam logic [IW-1:0] IDX_LAST = IW'(NCH - 1);
  localparam logic [IW-1:0] IDX_ONE  = IW'(1);
  localparam logic          INIT_ON  = (INIT_ASSERT != 0);

`ifdef RESET_SEQUENCER_CASCADE_EN
  localparam logic CASCADE_EN = 1'b1;
`else
  localparam logic CASCADE_EN = 1'b0;
`endif

  typedef enum logic [1:0] {
    ST_ASSERT,
    ST_HOLD,
    ST_SEQ,
    ST_RUN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [GW-1:0]   gap_q, gap_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [NCH-1:0]  out_q, out_d;
  logic [CW-1:0]   lcnt_q [NCH];
  logic [CW-1:0]   lcnt_d [NCH];

  logic [NCH-1:0]  req_eff;
  logic [NCH-1:0]  prev_ok;
  logic            casc_acc;

  // Effective per-channel request; in cascade mode a request spreads to every higher channel.
  always_comb begin
    req_eff  = ASSERT_IN;
    casc_acc = 1'b0;
    if (CASCADE_EN && (state_q == ST_SEQ || state_q == ST_RUN)) begin
      for (int i = 0; i < NCH; i++) begin
        casc_acc   = casc_acc | ASSERT_IN[i];
        req_eff[i] = casc_acc;
      end
    end
  end

  // Ordered RUN release: lower neighbour already released and the inter-release gap elapsed.
  always_comb begin
    prev_ok    = '0;
    prev_ok[0] = 1'b1;
    for (int i = 1; i < NCH; i++) begin
      prev_ok[i] = out_q[i-1] && (gap_q == '0);
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    idx_d   = idx_q;
    out_d   = out_q;
    lcnt_d  = lcnt_q;

    for (int i = 0; i < NCH; i++) begin
      if (req_eff[i]) begin
        lcnt_d[i] = CNT_HOLD;
      end else if (lcnt_q[i] != '0) begin
        lcnt_d[i] = lcnt_q[i] - CNT_ONE;
      end
    end

    unique case (state_q)
      ST_ASSERT: begin
        if (!ASSERT_ALL) begin
          state_d = ST_HOLD;
          cnt_d   = CNT_INIT;
        end
      end
      ST_HOLD: begin
        if (cnt_q == '0) begin
          state_d = ST_SEQ;
          idx_d   = '0;
          gap_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_ONE;
        end
      end
      ST_SEQ: begin
        if (gap_q != '0) begin
          gap_d = gap_q - GAP_ONE;
        end else if ((lcnt_q[idx_q] == '0) && !req_eff[idx_q]) begin
          out_d[idx_q] = 1'b1;
          gap_d        = GAP_LOAD;
          if (idx_q == IDX_LAST) begin
            state_d = ST_RUN;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end
      ST_RUN: begin
        if (CASCADE_EN && (gap_q != '0)) begin
          gap_d = gap_q - GAP_ONE;
        end
        for (int i = 0; i < NCH; i++) begin
          if (!req_eff[i] && (lcnt_q[i] == '0) && !out_q[i] &&
              (!CASCADE_EN || prev_ok[i])) begin
            out_d[i] = 1'b1;
            gap_d    = GAP_LOAD;
          end
        end
      end
      default: begin
        state_d = ST_ASSERT;
      end
    endcase

    // Requests beat any release on the same edge; the global assert beats everything.
    out_d = out_d & ~req_eff;
    if (ASSERT_ALL) begin
      state_d = ST_ASSERT;
      out_d   = '0;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= INIT_ON ? ST_HOLD : ST_RUN;
      cnt_q   <= CNT_INIT;
      gap_q   <= '0;
      idx_q   <= '0;
      out_q   <= {NCH{~INIT_ON}};
      for (int i = 0; i < NCH; i++) begin
        lcnt_q[i] <= '0;
      end
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      lcnt_q  <= lcnt_d;
    end
  end

  assign OUT_RST_N  = out_q;
  assign ASSERT_OUT = ~out_q;
  assign BUSY       = (state_q != ST_RUN);

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer (NCH=3, HOLD=4, GAP=2): directed plan steps plus random traffic,
// checked against a timestamp model (last request edge, earliest next release edge).
module tb_reset_sequencer;

  localparam int NCH  = 3;
  localparam int HOLD = 4;
  localparam int GAP  = 2;
  localparam int W    = NCH + 1;

`ifdef RESET_SEQUENCER_CASCADE_EN
  localparam bit CASC = 1'b1;
`else
  localparam bit CASC = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic           clk = 1'b0;
  logic           rst_n = 1'b0;
  logic           assert_all = 1'b0;
  logic [NCH-1:0] assert_in = '0;
  logic [NCH-1:0] out_rst_n;
  logic [NCH-1:0] assert_out;
  logic           busy;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NCH(NCH), .HOLD(HOLD), .GAP(GAP), .INIT_ASSERT(1)
  ) dut (
    .CLK(clk),
    .RST_N(rst_n),
    .ASSERT_ALL(assert_all),
    .ASSERT_IN(assert_in),
    .OUT_RST_N(out_rst_n),
    .ASSERT_OUT(assert_out),
    .BUSY(busy)
  );

  // ---------------- scoreboard ----------------
  int             checks = 0;
  int             failures = 0;
  logic [W-1:0]   exp_q[$];

  // ---------------- reference model ----------------
  // Edges are numbered from 1 after each reset release. A channel may come out of reset
  // only HOLD+1 edges after its last request; the sequence releases channels in order,
  // no earlier than ready_at, which is pushed GAP+1 edges forward after each release.
  int             now;
  int             ready_at;
  int             seq_start;
  int             seq_k;
  int             last_rise;
  int             t_in [NCH];
  logic [NCH-1:0] m_out;
  logic           m_busy;

  function automatic void model_reset();
    now       = 0;
    seq_k     = 0;
    ready_at  = HOLD + 1;
    seq_start = HOLD + 1;
    last_rise = -1000;
    for (int i = 0; i < NCH; i++) t_in[i] = -1000;
    m_out  = '0;
    m_busy = 1'b1;
  endfunction

  function automatic void model_edge(input logic aa, input logic [NCH-1:0] ai);
    logic [NCH-1:0] eff;
    logic [NCH-1:0] prev_out;
    logic           acc;
    logic           ok;
    logic           rose;
    now      = now + 1;
    prev_out = m_out;
    eff      = ai;
    if (CASC && (seq_k > 0 || now >= seq_start)) begin
      acc = 1'b0;
      for (int i = 0; i < NCH; i++) begin
        acc    = acc | ai[i];
        eff[i] = acc;
      end
    end
    for (int i = 0; i < NCH; i++) begin
      if (eff[i]) t_in[i] = now;
    end
    if (aa) begin
      m_out     = '0;
      seq_k     = 0;
      ready_at  = now + HOLD + 2;
      seq_start = ready_at;
    end else begin
      m_out = m_out & ~eff;
      if (seq_k < NCH) begin
        if (now >= ready_at && t_in[seq_k] <= now - HOLD - 1) begin
          m_out[seq_k] = 1'b1;
          seq_k        = seq_k + 1;
          ready_at     = now + GAP + 1;
          last_rise    = now;
        end
      end else begin
        rose = 1'b0;
        for (int i = 0; i < NCH; i++) begin
          ok = 1'b1;
          if (CASC && i > 0) ok = prev_out[i-1] && (now >= last_rise + GAP + 1);
          if (!eff[i] && !prev_out[i] && t_in[i] <= now - HOLD - 1 && ok) begin
            m_out[i] = 1'b1;
            rose     = 1'b1;
          end
        end
        if (rose) last_rise = now;
      end
    end
    m_busy = aa || (seq_k < NCH);
  endfunction

  // ---------------- checkers ----------------
  task automatic check_bits(input string tag, input logic [NCH-1:0] obs, input logic [NCH-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic check_busy(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s busy observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Called just after a falling edge: drive, step the model, let one rising edge pass, compare.
  task automatic step(input logic aa, input logic [NCH-1:0] ai, input string tag);
    logic [W-1:0] e;
    assert_all = aa;
    assert_in  = ai;
    model_edge(aa, ai);
    exp_q.push_back({m_busy, m_out});
    @(posedge clk);
    @(negedge clk);
    e = exp_q.pop_front();
    check_bits({tag, "_out"}, out_rst_n, e[NCH-1:0]);
    check_bits({tag, "_aout"}, assert_out, ~e[NCH-1:0]);
    check_busy({tag, "_busy"}, busy, e[NCH]);
  endtask

  task automatic idle_until(input int e, input string tag);
    while (now < e) step(1'b0, '0, tag);
  endtask

  // Asynchronous clear between edges, then one edge in reset before release.
  task automatic do_reset(input string tag);
    rst_n      = 1'b0;
    assert_all = 1'b0;
    assert_in  = '0;
    #1;
    check_bits({tag, "_out"}, out_rst_n, '0);
    check_bits({tag, "_aout"}, assert_out, '1);
    check_busy({tag, "_busy"}, busy, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // ---------------- directed + random stimulus ----------------
  logic [NCH-1:0] cur_ai;

  initial begin
    model_reset();
    @(negedge clk);
    do_reset("por");

    // Power-up sequence
    idle_until(4, "pu");
    check_bits("pu_e4", out_rst_n, 3'b000);
    idle_until(5, "pu");
    check_bits("pu_e5", out_rst_n, 3'b001);
    idle_until(8, "pu");
    check_bits("pu_e8", out_rst_n, 3'b011);
    idle_until(10, "pu");
    check_busy("pu_e10", busy, 1'b1);
    idle_until(11, "pu");
    check_bits("pu_e11", out_rst_n, 3'b111);
    check_busy("pu_e11", busy, 1'b0);

    // Global assert pulse in RUN
    idle_until(19, "run");
    step(1'b1, '0, "aa20");
    check_bits("aa_e20", out_rst_n, 3'b000);
    idle_until(25, "aa");
    check_bits("aa_e25", out_rst_n, 3'b000);
    idle_until(26, "aa");
    check_bits("aa_e26", out_rst_n, 3'b001);
    idle_until(29, "aa");
    check_bits("aa_e29", out_rst_n, 3'b011);
    idle_until(32, "aa");
    check_bits("aa_e32", out_rst_n, 3'b111);
    check_busy("aa_e32", busy, 1'b0);

    // Single-cycle per-channel request in RUN
    idle_until(39, "run");
    step(1'b0, 3'b010, "ch1_40");
`ifdef RESET_SEQUENCER_CASCADE_EN
    check_bits("ch1_e40", out_rst_n, 3'b001);
    idle_until(45, "ch1");
    check_bits("ch1_e45", out_rst_n, 3'b011);
    idle_until(48, "ch1");
    check_bits("ch1_e48", out_rst_n, 3'b111);
`else
    check_bits("ch1_e40", out_rst_n, 3'b101);
    check_busy("ch1_e40", busy, 1'b0);
    idle_until(44, "ch1");
    check_bits("ch1_e44", out_rst_n, 3'b101);
    idle_until(45, "ch1");
    check_bits("ch1_e45", out_rst_n, 3'b111);
`endif

    // Request on channel 0 in RUN
    idle_until(49, "run");
    step(1'b0, 3'b001, "ch0_50");
`ifdef RESET_SEQUENCER_CASCADE_EN
    check_bits("casc_e50", out_rst_n, 3'b000);
    idle_until(55, "casc");
    check_bits("casc_e55", out_rst_n, 3'b001);
    idle_until(58, "casc");
    check_bits("casc_e58", out_rst_n, 3'b011);
    idle_until(61, "casc");
    check_bits("casc_e61", out_rst_n, 3'b111);
`else
    check_bits("ch0_e50", out_rst_n, 3'b110);
    idle_until(55, "ch0");
    check_bits("ch0_e55", out_rst_n, 3'b111);
`endif

    // Async reset in the middle of a sequence
    idle_until(69, "run");
    step(1'b1, '0, "aa70");
    idle_until(77, "mid");
    check_bits("mid_e77", out_rst_n, 3'b001);
    do_reset("midrst");

    // Channel 1 held during the sequence stalls it
    while (now < 9) step(1'b0, 3'b010, "stall");
    idle_until(13, "stall");
    check_bits("stall_e13", out_rst_n, 3'b001);
    idle_until(14, "stall");
    check_bits("stall_e14", out_rst_n, 3'b011);
    idle_until(16, "stall");
    check_bits("stall_e16", out_rst_n, 3'b011);
    idle_until(17, "stall");
    check_bits("stall_e17", out_rst_n, 3'b111);

    // Global assert re-issued during SEQ, then during HOLD
    idle_until(24, "run");
    step(1'b1, '0, "aa25");
    idle_until(31, "reseq");
    check_bits("reseq_e31", out_rst_n, 3'b001);
    idle_until(32, "reseq");
    step(1'b1, '0, "aa33");
    check_bits("reseq_e33", out_rst_n, 3'b000);
    check_busy("reseq_e33", busy, 1'b1);
    idle_until(39, "reseq");
    check_bits("reseq_e39", out_rst_n, 3'b001);
    idle_until(45, "reseq");
    check_bits("reseq_e45", out_rst_n, 3'b111);
    idle_until(49, "run");
    step(1'b1, '0, "aa50");
    idle_until(52, "rehold");
    step(1'b1, '0, "aa53");
    idle_until(58, "rehold");
    check_bits("rehold_e58", out_rst_n, 3'b000);
    idle_until(59, "rehold");
    check_bits("rehold_e59", out_rst_n, 3'b001);
    idle_until(65, "rehold");
    check_bits("rehold_e65", out_rst_n, 3'b111);

    // Random traffic against the model
    cur_ai = '0;
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 249) == 0) do_reset("rnd_rst");
      if ($urandom_range(0, 5) == 0) begin
        if ($urandom_range(0, 2) == 0) begin
          cur_ai = '0;
        end else begin
          for (int b = 0; b < NCH; b++) cur_ai[b] = ($urandom_range(0, 4) == 0);
        end
      end
      step(($urandom_range(0, 39) == 0), cur_ai, "rnd");
    end
    idle_until(now + 40, "drain");

    // ---------------- final report ----------------
    checks++;
    assert (exp_q.size() == 0) else begin
      failures++;
      $error("FAIL scoreboard_drain observed=%0d expected=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
